// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE -> PLAY -> HIT/WIN pauses -> OVER.
// Generates the car advance strobe with a level-dependent period and keeps
// the level and score. Every output comes straight from a flop.
module game_sequencer #(
    parameter int BASE_PERIOD  = 2_500_000,
    parameter int PERIOD_STEP  = 250_000,
    parameter int MIN_PERIOD   = 500_000,
    parameter int DEATH_CYCLES = 12_500_000,
    parameter int WIN_CYCLES   = 12_500_000,
    parameter int MAX_LEVEL    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       frog_at_top,
    input  logic       collision_detected,
    input  logic [1:0] lives,
    output logic       reset_frog,
    output logic       car_tick,
    output logic       freeze,
    output logic [3:0] level,
    output logic [7:0] score,
    output logic       game_over,
    output logic [2:0] state
);

    localparam int PER_MAX   = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int CNT_W     = $clog2(PER_MAX + 1);
    localparam int PAUSE_MAX = (DEATH_CYCLES > WIN_CYCLES) ? DEATH_CYCLES : WIN_CYCLES;
    localparam int PAUSE_W   = $clog2(PAUSE_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [3:0]         level_r;
    logic [3:0]         level_nx_s;
    logic [7:0]         score_r;
    logic [7:0]         score_nx_s;
    logic [CNT_W-1:0]   tick_cnt_r;
    logic [CNT_W-1:0]   tick_cnt_nx_s;
    logic [PAUSE_W-1:0] pause_cnt_r;
    logic [PAUSE_W-1:0] pause_cnt_nx_s;
    logic               start_q_r;
    logic               coll_q_r;
    logic               car_tick_r;
    logic               car_tick_nx_s;
    logic               reset_frog_r;
    logic               freeze_r;
    logic               game_over_r;
    logic               enter_win_s;
    logic               start_rise_s;
    logic               coll_rise_s;
    logic [31:0]        level_steps_s;
    logic [CNT_W-1:0]   period_s;
    logic [CNT_W-1:0]   period_last_s;

    assign start_rise_s = start_btn & ~start_q_r;
    assign coll_rise_s  = collision_detected & ~coll_q_r;

    // Tick period for the current level, clamped to the floor without underflow.
    always_comb begin
        level_steps_s = (32'(level_r) - 32'd1) * 32'(PERIOD_STEP);
        if (BASE_PERIOD <= MIN_PERIOD) begin
            period_s = CNT_W'(MIN_PERIOD);
        end else if (level_steps_s >= 32'(BASE_PERIOD - MIN_PERIOD)) begin
            period_s = CNT_W'(MIN_PERIOD);
        end else begin
            period_s = CNT_W'(32'(BASE_PERIOD) - level_steps_s);
        end
        period_last_s = period_s - CNT_W'(1);
    end

    // Next-state, level, score and pause-counter decisions.
    always_comb begin
        state_nx_s     = state_r;
        level_nx_s     = level_r;
        score_nx_s     = score_r;
        pause_cnt_nx_s = '0;
        enter_win_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_nx_s = ST_PLAY;
                    level_nx_s = 4'd1;
                    score_nx_s = 8'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // A collision outranks reaching the top in the same cycle.
                if (coll_rise_s) begin
                    state_nx_s = (lives == 2'd0) ? ST_OVER : ST_HIT;
                end else if (frog_at_top) begin
                    state_nx_s  = ST_WIN;
                    enter_win_s = 1'b1;
                    score_nx_s  = (score_r == 8'd255) ? score_r : score_r + 8'd1;
                    level_nx_s  = (level_r >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_r + 4'd1;
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (pause_cnt_r >= PAUSE_W'(DEATH_CYCLES - 1)) begin
                    state_nx_s = ST_PLAY;
                end else begin
                    pause_cnt_nx_s = pause_cnt_r + PAUSE_W'(1);
                end
            end
            ST_WIN: begin
                if (pause_cnt_r >= PAUSE_W'(WIN_CYCLES - 1)) begin
                    state_nx_s = ST_PLAY;
                end else begin
                    pause_cnt_nx_s = pause_cnt_r + PAUSE_W'(1);
                end
            end
            ST_OVER: begin
                if (start_rise_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OVER;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Car tick counter: runs only while staying in PLAY, clears otherwise.
    always_comb begin
        tick_cnt_nx_s = '0;
        car_tick_nx_s = 1'b0;
        if ((state_r == ST_PLAY) && (state_nx_s == ST_PLAY)) begin
            if (tick_cnt_r >= period_last_s) begin
                car_tick_nx_s = 1'b1;
            end else begin
                tick_cnt_nx_s = tick_cnt_r + CNT_W'(1);
            end
        end else begin
            tick_cnt_nx_s = '0;
        end
    end

    // State, counters, edge registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            level_r      <= 4'd1;
            score_r      <= 8'd0;
            tick_cnt_r   <= '0;
            pause_cnt_r  <= '0;
            start_q_r    <= 1'b0;
            coll_q_r     <= 1'b0;
            car_tick_r   <= 1'b0;
            reset_frog_r <= 1'b1;
            freeze_r     <= 1'b1;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            level_r      <= level_nx_s;
            score_r      <= score_nx_s;
            tick_cnt_r   <= tick_cnt_nx_s;
            pause_cnt_r  <= pause_cnt_nx_s;
            start_q_r    <= start_btn;
            coll_q_r     <= collision_detected;
            car_tick_r   <= car_tick_nx_s;
            reset_frog_r <= (state_nx_s == ST_IDLE) || enter_win_s;
            freeze_r     <= (state_nx_s != ST_PLAY);
            game_over_r  <= (state_nx_s == ST_OVER);
        end
    end

    assign reset_frog = reset_frog_r;
    assign car_tick   = car_tick_r;
    assign freeze     = freeze_r;
    assign level      = level_r;
    assign score      = score_r;
    assign game_over  = game_over_r;
    assign state      = state_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with small timing parameters.
module tb_game_sequencer;

    localparam int BASE  = 8;
    localparam int STEP  = 2;
    localparam int MINP  = 4;
    localparam int DEATH = 5;
    localparam int WINC  = 3;
    localparam int MAXL  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       frog_at_top = 1'b0;
    logic       collision_detected = 1'b0;
    logic [1:0] lives = 2'd3;
    logic       reset_frog;
    logic       car_tick;
    logic       freeze;
    logic [3:0] level;
    logic [7:0] score;
    logic       game_over;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b1;

    game_sequencer #(
        .BASE_PERIOD (BASE),
        .PERIOD_STEP (STEP),
        .MIN_PERIOD  (MINP),
        .DEATH_CYCLES(DEATH),
        .WIN_CYCLES  (WINC),
        .MAX_LEVEL   (MAXL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_btn         (start_btn),
        .frog_at_top       (frog_at_top),
        .collision_detected(collision_detected),
        .lives             (lives),
        .reset_frog        (reset_frog),
        .car_tick          (car_tick),
        .freeze            (freeze),
        .level             (level),
        .score             (score),
        .game_over         (game_over),
        .state             (state)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = 0;
    int m_level = 1;
    int m_score = 0;
    int m_elapsed = 0;
    int m_remain = 0;
    bit m_tick = 1'b0;
    bit m_rf = 1'b1;
    bit m_ps = 1'b0;
    bit m_pc = 1'b0;

    function automatic int period_of(input int lv);
        int p;
        p = BASE - (lv - 1) * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    // Model update: game rules applied once per clock, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        bit sr;
        bit cr;
        bit win_entry;
        if (!rst_n) begin
            m_state = 0; m_level = 1; m_score = 0; m_elapsed = 0; m_remain = 0;
            m_tick = 1'b0; m_rf = 1'b1; m_ps = 1'b0; m_pc = 1'b0;
        end else begin
            sr = start_btn && !m_ps;
            cr = collision_detected && !m_pc;
            win_entry = 1'b0;
            m_tick = 1'b0;
            case (m_state)
                0: if (sr) begin
                    m_state = 1; m_level = 1; m_score = 0; m_elapsed = 0;
                end
                1: begin
                    m_elapsed++;
                    if (cr) begin
                        m_state = (lives == 2'd0) ? 4 : 2;
                        m_remain = DEATH;
                    end else if (frog_at_top) begin
                        m_state = 3;
                        m_remain = WINC;
                        win_entry = 1'b1;
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
                    end else if (m_elapsed % period_of(m_level) == 0) begin
                        m_tick = 1'b1;
                    end
                end
                2, 3: begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_state = 1;
                        m_elapsed = 0;
                    end
                end
                4: if (sr) m_state = 0;
                default: ;
            endcase
            m_rf = (m_state == 0) || win_entry;
            m_ps = start_btn;
            m_pc = collision_detected;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", int'(state), m_state);
            check("level", int'(level), m_level);
            check("score", int'(score), m_score);
            check("car_tick", int'(car_tick), int'(m_tick));
            check("freeze", int'(freeze), int'(m_state != 1));
            check("game_over", int'(game_over), int'(m_state == 4));
            check("reset_frog", int'(reset_frog), int'(m_rf));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!car_tick && cyc < 40);
        check("tick_seen", int'(car_tick), 1);
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (state != 3'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_play", int'(state), 1);
    endtask

    task automatic win_event(input int exp_period);
        int p;
        frog_at_top = 1'b1;
        @(negedge clk);
        frog_at_top = 1'b0;
        check("win_entered", int'(state), 3);
        check("win_reset_frog", int'(reset_frog), 1);
        wait_play();
        wait_tick(p);
        check("tick_period", p, exp_period);
    endtask

    initial begin
        int p;
        int n;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_reset_frog", int'(reset_frog), 1);
        check("rst_freeze", int'(freeze), 1);
        check("rst_level", int'(level), 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_state", int'(state), 0);
        check("idle_reset_frog", int'(reset_frog), 1);

        // Start: PLAY at level 1, tick every 8 cycles.
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        check("play_state", int'(state), 1);
        check("play_freeze", int'(freeze), 0);
        wait_tick(p);
        check("period_l1", p, 8);
        wait_tick(p);
        check("period_l1_again", p, 8);

        // Level progression 2/3/4 then saturation.
        win_event(6);
        check("level2", int'(level), 2);
        win_event(4);
        check("level3", int'(level), 3);
        win_event(4);
        check("level4", int'(level), 4);
        check("score3", int'(score), 3);
        win_event(4);
        check("level_sat", int'(level), 4);
        check("score4", int'(score), 4);

        // Collision with lives left: 5-cycle HIT, then counter restarts.
        lives = 2'd2;
        repeat (2) @(negedge clk);
        collision_detected = 1'b1;
        @(negedge clk);
        collision_detected = 1'b0;
        n = 0;
        while (state == 3'd2 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("hit_len", n, 5);
        check("after_hit_state", int'(state), 1);
        wait_tick(p);
        check("period_after_hit", p, 4);

        // Collision and top together: collision wins, score/level hold.
        lives = 2'd1;
        collision_detected = 1'b1;
        frog_at_top = 1'b1;
        @(negedge clk);
        collision_detected = 1'b0;
        frog_at_top = 1'b0;
        check("both_state", int'(state), 2);
        check("both_score", int'(score), 4);
        check("both_level", int'(level), 4);
        wait_play();

        // Last life lost: OVER; held start gives exactly one step to IDLE.
        lives = 2'd0;
        repeat (3) @(negedge clk);
        collision_detected = 1'b1;
        @(negedge clk);
        collision_detected = 1'b0;
        check("over_state", int'(state), 4);
        check("over_game_over", int'(game_over), 1);
        check("over_score", int'(score), 4);
        start_btn = 1'b1;
        repeat (6) @(negedge clk);
        check("held_start_idle", int'(state), 0);
        start_btn = 1'b0;
        lives = 2'd3;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 1);

        // Asynchronous reset during WIN.
        repeat (2) @(negedge clk);
        frog_at_top = 1'b1;
        @(negedge clk);
        frog_at_top = 1'b0;
        check("win_before_rst", int'(state), 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_level", int'(level), 1);
        check("arst_score", int'(score), 0);
        check("arst_reset_frog", int'(reset_frog), 1);
        check("arst_freeze", int'(freeze), 1);
        check("arst_car_tick", int'(car_tick), 0);
        check("arst_game_over", int'(game_over), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", int'(state), 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter BASE_PERIOD, 2_500_000, car_tick period at level 1, in clk cycles.
REQ-002 Parameter PERIOD_STEP, 250_000, period reduction per level above 1.
REQ-003 Parameter MIN_PERIOD, 500_000, floor on car_tick period.
REQ-004 Parameter DEATH_CYCLES, 12_500_000, HIT pause length, in clk cycles.
REQ-005 Parameter WIN_CYCLES, 12_500_000, WIN pause length, in clk cycles.
REQ-006 Parameter MAX_LEVEL, 9, level saturation value.
REQ-007 One clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-008 start_btn input 1: debounced start/restart button, active-high.
REQ-009 frog_at_top input 1: frog is on row 0.
REQ-010 collision_detected input 1: frog controller collision flag.
REQ-011 lives input 2: lives remaining, already decremented in the same cycle that collision_detected rises.
REQ-012 reset_frog output 1: frog controller reset (recentre frog, lives to 3).
REQ-013 car_tick output 1: one-cycle strobe that advances all cars.
REQ-014 freeze output 1: block frog movement; high whenever state is not PLAY.
REQ-015 level output 4: current level, 1..MAX_LEVEL.
REQ-016 score output 8: frogs delivered to the top, saturating.
REQ-017 game_over output 1: high in OVER.
REQ-018 state output 3: IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4.

Function
REQ-019 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-020 start_btn SHALL be edge-detected; start_rise = start_btn high while its registered copy is low.
REQ-021 IDLE SHALL hold reset_frog=1 and car_tick=0; on start_rise, go to PLAY and set level=1, score=0.
REQ-022 In PLAY, a rising edge of collision_detected SHALL go to OVER if lives==0, otherwise to HIT.
REQ-023 In PLAY, frog_at_top=1 with no collision rise SHALL go to WIN, with score+1 saturating at 255 and level+1 saturating at MAX_LEVEL.
REQ-024 A collision rise and frog_at_top in the same cycle SHALL be treated as a collision; score and level are unchanged.
REQ-025 HIT SHALL last exactly DEATH_CYCLES cycles, then return to PLAY; the pause counter clears on entry.
REQ-026 WIN SHALL last exactly WIN_CYCLES cycles and assert reset_frog only on its first cycle, then return to PLAY.
REQ-027 OVER SHALL hold game_over=1 and keep level and score for display; on start_rise, go to IDLE.
REQ-028 Tick period P SHALL be max(MIN_PERIOD, BASE_PERIOD - (level-1)*PERIOD_STEP), computed without underflow; the subtraction SHALL be guarded and clamped.
REQ-029 Tick counter behaviour in PLAY:
- counts 0..P-1;
- car_tick=1 in the cycle after the counter reaches P-1, then the counter wraps to 0;
- the counter clears on every entry to PLAY;
- it holds at 0 outside PLAY.
REQ-030 car_tick SHALL never be asserted outside PLAY.
REQ-031 A level change mid-count SHALL take effect at the next wrap, or earlier if the counter is already at or beyond the new P-1, in which case it wraps on the next cycle.
REQ-032 start_btn outside IDLE and OVER SHALL be ignored.

Reset
REQ-033 While rst_n is low, the block SHALL hold:
- state=IDLE, level=1, score=0;
- car_tick=0, game_over=0;
- freeze=1, reset_frog=1;
- counters and the start edge register at 0.
REQ-034 Asserting rst_n mid-game SHALL abort any state immediately; after release, the block waits in IDLE for start_rise.

Verification
Bench parameters: BASE_PERIOD=8, PERIOD_STEP=2, MIN_PERIOD=4, DEATH_CYCLES=5, WIN_CYCLES=3, MAX_LEVEL=4.
REQ-035 Reset, then start pulse -> IDLE with reset_frog=1; then PLAY, level=1, car_tick every 8 cycles, freeze=0.
REQ-036 Three frog_at_top events -> level 2/3/4 with periods 6/4/4; score=3; a fourth event leaves level=4 and sets score=4.
REQ-037 Collision rise with lives=2 -> HIT for exactly 5 cycles with car_tick=0 and freeze=1, then PLAY with the tick counter restarted.
REQ-038 Collision rise with lives=0 -> OVER, game_over=1; start held high gives one transition to IDLE only; a second press gives PLAY with score=0.
REQ-039 Collision rise and frog_at_top in the same cycle with lives=1 -> HIT, score and level unchanged.
REQ-040 rst_n low during WIN -> IDLE asynchronously with all outputs at reset values.
